// File: rtl/dmd_scan_ctrl.sv
// dmd_scan_ctrl: row-scan controller for the 16x16 dot-matrix display.
// Fetches one 16-bit row from frame memory, blanks the panel, drives the
// row select and column data, strobes the latch clock, then holds the row
// for DWELL cycles before moving on. Rows 0..15 are walked continuously
// while 'en' is high.
// Optional feature macro: DMD_BRIGHT_EN (PWM-style brightness within HOLD).
module dmd_scan_ctrl #(
    parameter int unsigned DWELL     = 1000,
    parameter int unsigned BLANK_CYC = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        en,
    input  logic [1:0]  bright,
    input  logic [15:0] rd_data,
    output logic        rd_en,
    output logic [3:0]  rd_addr,
    output logic [3:0]  dmd_seg,
    output logic [15:0] dmd_column,
    output logic        DMD_CLK,
    output logic        DMD_CLR,
    output logic        frame_start
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BLANK,
        S_FETCH,
        S_LOAD,
        S_LATCH,
        S_HOLD
    } state_t;

    // Terminal counts; both counters count up from 0 after each state entry.
    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYC - 1);

    state_t      state_q;
    logic [3:0]  row_q;
    logic [15:0] cnt_q;
    logic        rd_en_q;
    logic [3:0]  rd_addr_q;
    logic [3:0]  seg_q;
    logic [15:0] col_q;
    logic        clk_q;
    logic        clr_q;
    logic        fs_q;

`ifdef DMD_BRIGHT_EN
    logic [15:0] thresh_q;
    logic [15:0] thresh_d;
    logic [17:0] prod;

    // Lit-cycle threshold T = ((bright+1)*DWELL)>>2, never below 1.
    always_comb begin
        prod     = 18'({1'b0, bright} + 3'd1) * 18'(DWELL);
        thresh_d = 16'(prod >> 2);
        if (thresh_d == 16'd0) begin
            thresh_d = 16'd1;
        end
    end
`else
    // Brightness input is kept on the port list but has no effect here.
    logic unused_bright;
    assign unused_bright = ^bright;
`endif

    // Scan FSM: every output is a register updated together with the state.
    // The row counter survives a pass through IDLE, so re-enabling after a
    // mid-frame stop resumes at the next row rather than at row 0.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            row_q     <= 4'd0;
            cnt_q     <= 16'd0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= 4'd0;
            seg_q     <= 4'd0;
            col_q     <= 16'd0;
            clk_q     <= 1'b0;
            clr_q     <= 1'b1;
            fs_q      <= 1'b0;
`ifdef DMD_BRIGHT_EN
            thresh_q  <= 16'd1;
`endif
        end else begin
            rd_en_q <= 1'b0;
            fs_q    <= 1'b0;
            clk_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    clr_q <= 1'b1;
                    col_q <= 16'd0;
                    if (en) begin
                        state_q <= S_BLANK;
                        cnt_q   <= 16'd0;
                    end
                end
                S_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_q   <= S_FETCH;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= row_q;
                        fs_q      <= (row_q == 4'd0);
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_FETCH: begin
                    state_q <= S_LOAD;
                    seg_q   <= row_q;
                    clr_q   <= 1'b0;
                end
                S_LOAD: begin
                    state_q <= S_LATCH;
                    col_q   <= rd_data;
                    clk_q   <= 1'b1;
`ifdef DMD_BRIGHT_EN
                    thresh_q <= thresh_d;
`endif
                end
                S_LATCH: begin
                    state_q <= S_HOLD;
                    cnt_q   <= 16'd0;
                end
                S_HOLD: begin
                    if (cnt_q == DWELL_LAST) begin
                        row_q <= row_q + 4'd1;
                        clr_q <= 1'b1;
                        col_q <= 16'd0;
                        cnt_q <= 16'd0;
                        if (en) begin
                            state_q <= S_BLANK;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
`ifdef DMD_BRIGHT_EN
                        if ((cnt_q + 16'd1) >= thresh_q) begin
                            col_q <= 16'd0;
                            clr_q <= 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    clr_q   <= 1'b1;
                    col_q   <= 16'd0;
                end
            endcase
        end
    end

    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign dmd_seg     = seg_q;
    assign dmd_column  = col_q;
    assign DMD_CLK     = clk_q;
    assign DMD_CLR     = clr_q;
    assign frame_start = fs_q;

endmodule
